// File: rtl/mem_access_sequencer.sv
// Sequences fetch and load/store accesses onto one shared single-port SRAM.
// Define MISALIGN_TRAP_EN to trap misaligned half/word data accesses with dm_err.
module mem_access_sequencer #(
    parameter int unsigned DATA_SIZE  = 32,
    parameter int unsigned ADDR_WIDTH = 14,
    parameter int unsigned READ_LAT   = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [DATA_SIZE-1:0]  if_addr,
    output logic                  if_done,
    output logic [DATA_SIZE-1:0]  if_rdata,
    input  logic                  dm_req,
    input  logic                  dm_we,
    input  logic [1:0]            dm_size,
    input  logic                  dm_unsigned,
    input  logic [DATA_SIZE-1:0]  dm_addr,
    input  logic [DATA_SIZE-1:0]  dm_wdata,
    output logic                  dm_done,
    output logic [DATA_SIZE-1:0]  dm_rdata,
    output logic                  dm_err,
    output logic                  mem_cs,
    output logic                  mem_oe,
    output logic [3:0]            mem_web,
    output logic [2:0]            mem_type,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_SIZE-1:0]  mem_din,
    input  logic [DATA_SIZE-1:0]  mem_dout
);

    localparam int unsigned CNT_W = 2;

    localparam logic [1:0] SZ_BYTE = 2'b00;
    localparam logic [1:0] SZ_HALF = 2'b01;
    localparam logic [1:0] SZ_WORD = 2'b10;
    localparam logic [1:0] SZ_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        RESP  = 2'd3
    } state_t;

    state_t           state;
    logic             last_dm;
    logic             sel_dm;
    logic             lat_we;
    logic [1:0]       lat_size;
    logic             lat_uns;
    logic [1:0]       lat_lo;
    logic [CNT_W-1:0] cnt;

    logic                 grant_dm_c;
    logic                 misalign_c;
    logic [3:0]           st_web_c;
    logic [DATA_SIZE-1:0] st_din_c;
    logic [2:0]           dm_type_c;
    logic [7:0]           ld_byte_c;
    logic [15:0]          ld_half_c;
    logic [DATA_SIZE-1:0] ld_data_c;

    // Round-robin: data wins a tie unless it won the previous grant.
    assign grant_dm_c = dm_req && (!if_req || !last_dm);

`ifdef MISALIGN_TRAP_EN
    assign misalign_c = ((dm_size == SZ_HALF) && dm_addr[0]) ||
                        ((dm_size == SZ_WORD) && (dm_addr[1:0] != 2'b00));
`else
    assign misalign_c = 1'b0;
`endif

    // Store lane placement and access type for the pending data request.
    always_comb begin
        st_web_c  = 4'b1111;
        st_din_c  = '0;
        dm_type_c = 3'b010;
        case (dm_size)
            SZ_BYTE: begin
                st_web_c  = ~(4'b0001 << dm_addr[1:0]);
                st_din_c  = DATA_SIZE'(dm_wdata[7:0]) << {dm_addr[1:0], 3'b000};
                dm_type_c = {dm_addr[1], SZ_BYTE};
            end
            SZ_HALF: begin
                if (dm_addr[1]) begin
                    st_web_c = 4'b0011;
                    st_din_c = DATA_SIZE'({dm_wdata[15:0], 16'h0000});
                end else begin
                    st_web_c = 4'b1100;
                    st_din_c = DATA_SIZE'(dm_wdata[15:0]);
                end
                dm_type_c = {dm_addr[1], SZ_HALF};
            end
            SZ_WORD: begin
                st_web_c  = 4'b0000;
                st_din_c  = dm_wdata;
                dm_type_c = {1'b0, SZ_WORD};
            end
            default: begin
                st_web_c  = 4'b1111;
                st_din_c  = '0;
                dm_type_c = 3'b010;
            end
        endcase
    end

    // Load lane extraction and sign/zero extension from the SRAM word.
    always_comb begin
        ld_byte_c = 8'(mem_dout >> {lat_lo, 3'b000});
        ld_half_c = lat_lo[1] ? mem_dout[31:16] : mem_dout[15:0];
        ld_data_c = mem_dout;
        case (lat_size)
            SZ_BYTE: begin
                if (lat_uns) ld_data_c = DATA_SIZE'(ld_byte_c);
                else         ld_data_c = DATA_SIZE'({{24{ld_byte_c[7]}}, ld_byte_c});
            end
            SZ_HALF: begin
                if (lat_uns) ld_data_c = DATA_SIZE'(ld_half_c);
                else         ld_data_c = DATA_SIZE'({{16{ld_half_c[15]}}, ld_half_c});
            end
            default: ld_data_c = mem_dout;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            last_dm  <= 1'b0;
            sel_dm   <= 1'b0;
            lat_we   <= 1'b0;
            lat_size <= SZ_WORD;
            lat_uns  <= 1'b0;
            lat_lo   <= 2'b00;
            cnt      <= '0;
            if_done  <= 1'b0;
            if_rdata <= '0;
            dm_done  <= 1'b0;
            dm_rdata <= '0;
            dm_err   <= 1'b0;
            mem_cs   <= 1'b0;
            mem_oe   <= 1'b0;
            mem_web  <= 4'b1111;
            mem_type <= 3'b010;
            mem_addr <= '0;
            mem_din  <= '0;
        end else begin
            if_done <= 1'b0;
            dm_done <= 1'b0;
            mem_cs  <= 1'b0;
            mem_oe  <= 1'b0;
            mem_web <= 4'b1111;
            case (state)
                IDLE: begin
                    if (grant_dm_c) begin
                        sel_dm   <= 1'b1;
                        lat_we   <= dm_we;
                        lat_size <= dm_size;
                        lat_uns  <= dm_unsigned;
                        lat_lo   <= dm_addr[1:0];
                        if ((dm_size == SZ_RSVD) || misalign_c) begin
                            // No SRAM access: answer directly.
                            dm_rdata <= '0;
                            dm_err   <= misalign_c;
                            dm_done  <= 1'b1;
                            state    <= RESP;
                        end else begin
                            mem_cs   <= 1'b1;
                            mem_addr <= dm_addr[ADDR_WIDTH+1:2];
                            mem_type <= dm_type_c;
                            if (dm_we) begin
                                mem_web <= st_web_c;
                                mem_din <= st_din_c;
                            end else begin
                                mem_oe <= 1'b1;
                            end
                            state <= ISSUE;
                        end
                    end else if (if_req) begin
                        sel_dm   <= 1'b0;
                        lat_we   <= 1'b0;
                        mem_cs   <= 1'b1;
                        mem_oe   <= 1'b1;
                        mem_addr <= if_addr[ADDR_WIDTH+1:2];
                        mem_type <= 3'b010;
                        state    <= ISSUE;
                    end
                end
                ISSUE: begin
                    if (sel_dm && lat_we) begin
                        dm_err  <= 1'b0;
                        dm_done <= 1'b1;
                        state   <= RESP;
                    end else begin
                        cnt   <= CNT_W'(READ_LAT - 1);
                        state <= WAIT;
                    end
                end
                WAIT: begin
                    if (cnt == '0) begin
                        if (sel_dm) begin
                            dm_rdata <= ld_data_c;
                            dm_err   <= 1'b0;
                            dm_done  <= 1'b1;
                        end else begin
                            if_rdata <= mem_dout;
                            if_done  <= 1'b1;
                        end
                        state <= RESP;
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    last_dm <= sel_dm;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Address bits outside the SRAM word range are intentionally ignored.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{if_addr[1:0], if_addr[DATA_SIZE-1:ADDR_WIDTH+2],
                                dm_addr[DATA_SIZE-1:ADDR_WIDTH+2]};

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Directed self-checking bench for mem_access_sequencer with a small SRAM model.
module tb_mem_access_sequencer;

    localparam int unsigned DS = 32;
    localparam int unsigned AW = 14;
    localparam int unsigned RL = 1;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          if_req = 1'b0;
    logic [DS-1:0] if_addr = '0;
    logic          if_done;
    logic [DS-1:0] if_rdata;
    logic          dm_req = 1'b0;
    logic          dm_we = 1'b0;
    logic [1:0]    dm_size = 2'b10;
    logic          dm_unsigned = 1'b0;
    logic [DS-1:0] dm_addr = '0;
    logic [DS-1:0] dm_wdata = '0;
    logic          dm_done;
    logic [DS-1:0] dm_rdata;
    logic          dm_err;
    logic          mem_cs;
    logic          mem_oe;
    logic [3:0]    mem_web;
    logic [2:0]    mem_type;
    logic [AW-1:0] mem_addr;
    logic [DS-1:0] mem_din;
    logic [DS-1:0] mem_dout;

    always #5 clk = ~clk;

    mem_access_sequencer #(.DATA_SIZE(DS), .ADDR_WIDTH(AW), .READ_LAT(RL)) dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .dm_req(dm_req), .dm_we(dm_we), .dm_size(dm_size), .dm_unsigned(dm_unsigned),
        .dm_addr(dm_addr), .dm_wdata(dm_wdata), .dm_done(dm_done), .dm_rdata(dm_rdata),
        .dm_err(dm_err), .mem_cs(mem_cs), .mem_oe(mem_oe), .mem_web(mem_web),
        .mem_type(mem_type), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
    );

    // SRAM model: 16 words, one-cycle synchronous read, byte-lane writes.
    logic [DS-1:0] mem_model [16];
    logic          load_en = 1'b0;
    logic [3:0]    load_idx = '0;
    logic [DS-1:0] load_val = '0;

    always @(posedge clk) begin
        if (load_en) mem_model[load_idx] <= load_val;
        else if (mem_cs) begin
            if (mem_oe) mem_dout <= mem_model[mem_addr[3:0]];
            for (int b = 0; b < 4; b++)
                if (!mem_web[b]) mem_model[mem_addr[3:0]][8*b +: 8] <= mem_din[8*b +: 8];
        end
    end

    int n_tests = 0;
    int n_fail  = 0;

    int            cap_lat;
    logic          cap_cs;
    logic          cap_oe;
    logic [3:0]    cap_web;
    logic [2:0]    cap_type;
    logic [AW-1:0] cap_addr;
    logic [DS-1:0] cap_din;
    logic          cap_err;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [3:0] idx, input logic [DS-1:0] val);
        @(negedge clk);
        load_en = 1'b1; load_idx = idx; load_val = val;
        @(negedge clk);
        load_en = 1'b0;
    endtask

    task automatic clear_cap();
        cap_lat = 0; cap_cs = 1'b0; cap_oe = 1'b0; cap_web = 4'hF;
        cap_type = '0; cap_addr = '0; cap_din = '0; cap_err = 1'b0;
    endtask

    // Issues one data request; records latency and the ISSUE-cycle SRAM controls.
    task automatic run_dm(input logic we, input logic [1:0] size, input logic uns,
                          input logic [DS-1:0] addr, input logic [DS-1:0] wdata);
        @(negedge clk);
        dm_we = we; dm_size = size; dm_unsigned = uns; dm_addr = addr; dm_wdata = wdata;
        dm_req = 1'b1;
        clear_cap();
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (mem_cs) begin
                cap_cs = 1'b1; cap_oe = mem_oe; cap_web = mem_web;
                cap_type = mem_type; cap_addr = mem_addr; cap_din = mem_din;
            end
            if (dm_done) begin
                cap_lat = n; cap_err = dm_err;
                break;
            end
        end
        dm_req = 1'b0;
        if (cap_lat == 0) check_eq("dm_timeout", 32'(dm_done), 32'd1);
        @(posedge clk); @(posedge clk); #1;
    endtask

    task automatic run_if(input logic [DS-1:0] addr);
        @(negedge clk);
        if_addr = addr; if_req = 1'b1;
        clear_cap();
        for (int n = 1; n <= 20; n++) begin
            @(posedge clk); #1;
            if (mem_cs) begin
                cap_cs = 1'b1; cap_oe = mem_oe; cap_web = mem_web;
                cap_type = mem_type; cap_addr = mem_addr;
            end
            if (if_done) begin
                cap_lat = n;
                break;
            end
        end
        if_req = 1'b0;
        if (cap_lat == 0) check_eq("if_timeout", 32'(if_done), 32'd1);
        @(posedge clk); @(posedge clk); #1;
    endtask

    logic any_done;
    int   order [4];
    int   ng;

    initial begin
        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check_eq("rst_done", {30'd0, if_done, dm_done}, 32'd0);
        check_eq("rst_cs_oe_err", {29'd0, mem_cs, mem_oe, dm_err}, 32'd0);
        check_eq("rst_web", 32'(mem_web), 32'hF);
        check_eq("rst_type", 32'(mem_type), 32'h2);
        check_eq("rst_addr", 32'(mem_addr), 32'h0);
        check_eq("rst_din", mem_din, 32'h0);
        check_eq("rst_rdata", if_rdata | dm_rdata, 32'h0);
        @(negedge clk); rst = 1'b1;

        preload(4'd0, 32'h1122_3344);
        preload(4'd1, 32'hCAFE_F00D);
        preload(4'd2, 32'h0000_0000);
        preload(4'd4, 32'h1357_9BDF);

        // Reset in the middle of a load aborts it without a done pulse
        @(negedge clk);
        dm_we = 1'b0; dm_size = 2'b10; dm_addr = 32'h8; dm_req = 1'b1;
        @(posedge clk); #1;
        check_eq("midload_issue_cs", 32'(mem_cs), 32'd1);
        rst = 1'b0; #1;
        check_eq("midload_rst_web", 32'(mem_web), 32'hF);
        check_eq("midload_rst_cs", 32'(mem_cs), 32'd0);
        dm_req = 1'b0;
        any_done = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk); #1;
            any_done = any_done | dm_done;
        end
        @(negedge clk); rst = 1'b1;
        for (int i = 0; i < 3; i++) begin
            @(posedge clk); #1;
            any_done = any_done | dm_done;
        end
        check_eq("midload_no_done", 32'(any_done), 32'd0);

        run_if(32'h10);
        check_eq("fetch_addr", 32'(cap_addr), 32'h4);
        check_eq("fetch_oe_web", {27'd0, cap_oe, cap_web}, 32'h1F);
        check_eq("fetch_lat", 32'(cap_lat), 32'd2 + RL);
        check_eq("fetch_rdata", if_rdata, 32'h1357_9BDF);

        // Byte store to lane 3
        run_dm(1'b1, 2'b00, 1'b0, 32'h103, 32'hFFFF_FFA5);
        check_eq("sb_web", 32'(cap_web), 32'h7);
        check_eq("sb_din", cap_din, 32'hA500_0000);
        check_eq("sb_type", 32'(cap_type), 32'h4);
        check_eq("sb_addr", 32'(cap_addr), 32'h40);
        check_eq("sb_oe", 32'(cap_oe), 32'd0);
        check_eq("sb_lat", 32'(cap_lat), 32'd2);
        check_eq("sb_mem", mem_model[0], 32'hA522_3344);

        // Sub-word loads
        preload(4'd0, 32'h8001_1234);
        run_dm(1'b0, 2'b01, 1'b0, 32'h102, 32'h0);
        check_eq("lh_s_rdata", dm_rdata, 32'hFFFF_8001);
        check_eq("lh_s_type", 32'(cap_type), 32'h5);
        check_eq("lh_s_lat", 32'(cap_lat), 32'd2 + RL);
        check_eq("lh_s_oe_web", {27'd0, cap_oe, cap_web}, 32'h1F);
        run_dm(1'b0, 2'b01, 1'b1, 32'h102, 32'h0);
        check_eq("lh_u_rdata", dm_rdata, 32'h0000_8001);
        run_dm(1'b0, 2'b01, 1'b0, 32'h100, 32'h0);
        check_eq("lh_lo_rdata", dm_rdata, 32'h0000_1234);
        run_dm(1'b0, 2'b00, 1'b1, 32'h101, 32'h0);
        check_eq("lbu_rdata", dm_rdata, 32'h0000_0012);
        check_eq("lbu_type", 32'(cap_type), 32'h0);
        run_dm(1'b0, 2'b00, 1'b0, 32'h103, 32'h0);
        check_eq("lb_s_rdata", dm_rdata, 32'hFFFF_FF80);

        // Half and word stores
        run_dm(1'b1, 2'b01, 1'b0, 32'h2, 32'h0000_BEEF);
        check_eq("sh_web", 32'(cap_web), 32'h3);
        check_eq("sh_din", cap_din, 32'hBEEF_0000);
        check_eq("sh_mem", mem_model[0], 32'hBEEF_1234);
        run_dm(1'b1, 2'b10, 1'b0, 32'h8, 32'hDEAD_BEEF);
        check_eq("sw_web_type", {25'd0, cap_type, cap_web}, 32'h20);
        check_eq("sw_mem", mem_model[2], 32'hDEAD_BEEF);

        // Fetch leaves last_dm clear, so data wins the first tie
        run_if(32'h10);
        @(negedge clk);
        dm_we = 1'b0; dm_size = 2'b10; dm_addr = 32'h4; dm_req = 1'b1;
        if_addr = 32'h10; if_req = 1'b1;
        ng = 0;
        for (int i = 0; i < 4; i++) order[i] = -1;
        for (int n = 0; n < 40 && ng < 4; n++) begin
            @(posedge clk); #1;
            if (dm_done && ng < 4) begin order[ng] = 1; ng++; end
            if (if_done && ng < 4) begin order[ng] = 0; ng++; end
        end
        dm_req = 1'b0; if_req = 1'b0;
        if (ng < 4) check_eq("arb_timeout", 32'(ng), 32'd4);
        check_eq("arb_grant0_data", 32'(order[0]), 32'd1);
        check_eq("arb_grant1_fetch", 32'(order[1]), 32'd0);
        check_eq("arb_grant2_data", 32'(order[2]), 32'd1);
        check_eq("arb_grant3_fetch", 32'(order[3]), 32'd0);
        check_eq("arb_dm_rdata", dm_rdata, 32'hCAFE_F00D);
        check_eq("arb_if_rdata", if_rdata, 32'h1357_9BDF);
        @(posedge clk); @(posedge clk); #1;

        // Misaligned word load
        run_dm(1'b0, 2'b10, 1'b0, 32'h6, 32'h0);
`ifdef MISALIGN_TRAP_EN
        check_eq("mis_err", 32'(cap_err), 32'd1);
        check_eq("mis_no_cs", 32'(cap_cs), 32'd0);
        check_eq("mis_lat", 32'(cap_lat), 32'd1);
        check_eq("mis_rdata", dm_rdata, 32'h0);
`else
        check_eq("mis_err", 32'(cap_err), 32'd0);
        check_eq("mis_addr", 32'(cap_addr), 32'h1);
        check_eq("mis_lat", 32'(cap_lat), 32'd2 + RL);
        check_eq("mis_rdata", dm_rdata, 32'hCAFE_F00D);
`endif

        // Reserved size: no SRAM access, immediate response
        run_dm(1'b1, 2'b11, 1'b0, 32'h20, 32'h1234_5678);
        check_eq("rsv_no_cs", 32'(cap_cs), 32'd0);
        check_eq("rsv_lat", 32'(cap_lat), 32'd1);
        check_eq("rsv_rdata", dm_rdata, 32'h0);
        check_eq("rsv_err", 32'(cap_err), 32'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_access_sequencer.md
# mem_access_sequencer

Sequences all CPU accesses to one shared single-port 32-bit data/instruction SRAM. Arbitrates between the instruction-fetch port and the data (load/store) port, drives byte lanes and active-low byte write enables for sub-word stores, waits the memory read latency, and returns lane-extracted, sign- or zero-extended load data with a one-cycle done pulse. Sits between the core's IF/MEM stages and the SRAM wrapper.

## Interface
- DATA_SIZE, 32, data and byte-address width
- ADDR_WIDTH, 14, SRAM word-address width
- READ_LAT, 1, SRAM cycles from the access cycle to valid `mem_dout` (1..4)
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset
- if_req  in  1  fetch request; held with `if_addr` stable until `if_done`
- if_addr  in  DATA_SIZE  fetch byte address; bits [1:0] ignored
- if_done  out  1  one-cycle pulse, fetch complete
- if_rdata  out  DATA_SIZE  fetched word; held until next `if_done`
- dm_req  in  1  data request; all dm_* inputs held stable until `dm_done`
- dm_we  in  1  1 = store, 0 = load
- dm_size  in  2  00 byte, 01 half, 10 word, 11 reserved
- dm_unsigned  in  1  load zero-extend (1) or sign-extend (0)
- dm_addr  in  DATA_SIZE  data byte address
- dm_wdata  in  DATA_SIZE  store data, right-aligned
- dm_done  out  1  one-cycle pulse, data access complete
- dm_rdata  out  DATA_SIZE  extended load data; held until next `dm_done`
- dm_err  out  1  misaligned-access flag, valid with `dm_done`
- mem_cs  out  1  SRAM chip select
- mem_oe  out  1  SRAM output enable (loads/fetches)
- mem_web  out  4  active-low byte write enables, bit n = byte lane n
- mem_type  out  3  access type: bit2 = upper half, [1:0] = size (000 byte lo, 100 byte hi, 001 half lo, 101 half hi, 010 word)
- mem_addr  out  ADDR_WIDTH  word address = byte address [ADDR_WIDTH+1:2]
- mem_din  out  DATA_SIZE  lane-positioned store data
- mem_dout  in  DATA_SIZE  SRAM read data

## Operation
- FSM states: IDLE, ISSUE, WAIT, RESP. All outputs registered.
- IDLE: if any req, latch winner's fields, go ISSUE. Both pending: round-robin; `last_dm` flag (reset 0) → data wins when `last_dm`=0, else fetch. Single requester always wins.
- ISSUE (1 cycle): mem_cs=1, mem_addr/mem_type driven. Fetch/load: mem_oe=1, mem_web=4'b1111. Store: mem_oe=0; byte: web lane n low only (addr[1:0]=00→1110, 01→1101, 10→1011, 11→0111), wdata[7:0] replicated to that lane, other lanes 0; half: addr[1]=0→1100, data in [15:0]; addr[1]=1→0011, data in [31:16]; word: 0000, data unchanged. Store → RESP; load/fetch → WAIT.
- WAIT: count READ_LAT-1 cycles (0 → leave immediately); capture `mem_dout` in last cycle; → RESP.
- RESP (1 cycle): pulse winner's done; loads: select lane by latched addr, extend per dm_unsigned; fetch: word as-is. → IDLE. `last_dm` updated to winner==data.
- dm_size=11: no SRAM access (cs=0, web=1111), ISSUE skipped, RESP with dm_rdata=0, dm_err=0.
- Requester dropping req before done: undefined; not checked.

## Timing
- Reset values: all done/err/mem_cs/mem_oe 0, mem_web 4'b1111, mem_type 3'b010, mem_addr/mem_din/rdata 0, state IDLE, last_dm 0.
- Req seen at edge k in IDLE → ISSUE cycle k+1 → done pulse: store k+2; load/fetch k+2+READ_LAT.
- One access in flight; next request accepted in IDLE after RESP (min 3-cycle store period).
- Outside ISSUE: mem_cs=0, mem_oe=0, mem_web=1111.
- Reset mid-access: abort immediately, outputs to reset values, no done pulse; requester must re-issue.

## Configuration
- MISALIGN_TRAP_EN defined: half with addr[0]=1 or word with addr[1:0]≠00 → no SRAM access, RESP next cycle with dm_done=1, dm_err=1, dm_rdata=0.
- Undefined: dm_err tied 0; word ignores addr[1:0], half ignores addr[0].

## Test plan
- Reset low mid-load → mem_web=1111, cs=0, no dm_done; after release first fetch of 0x10 gives mem_addr=4, if_done at k+3 (READ_LAT=1).
- Store byte 0xA5 to 0x103 → ISSUE: mem_web=0111, mem_din=0xA5000000, mem_type=100, mem_addr=0x40; dm_done at k+2.
- Load half signed at 0x102, mem_dout=0x8001_1234 → dm_rdata=0xFFFF8001; unsigned → 0x00008001.
- if_req and dm_req both high continuously → grants alternate data, fetch, data, fetch.
- MISALIGN_TRAP_EN: word load at 0x6 → dm_done with dm_err=1, mem_cs never 1; without macro → word from mem_addr=1, dm_err=0.
- dm_size=11 store → no cs, dm_done next cycle after IDLE, dm_rdata=0.
